mpu_poll_seq: RTL and testbench
===============================

MPU_POLL_SEQ -- requirements
Module: mpu_poll_seq

Interface
REQ-001 SHALL have parameter FPGA_CLK, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter POLL_HZ, default 100, sensor frame rate in Hz.
REQ-003 SHALL have parameter MAX_RETRY, default 3, number of re-issues allowed per instruction before fault.
REQ-004 SHALL have parameter ACC_TMO, default 16, number of cycles allowed for controller to assert busy after enable.
REQ-005 SHALL have port CLK, input, 1 bit, system clock.
REQ-006 SHALL have port RST_n, input, 1 bit, reset; RST_n is asynchronous and active-low, and the clock is CLK.
REQ-007 SHALL have port I_START, input, 1 bit, one-cycle pulse that starts init followed by polling.
REQ-008 SHALL have port I_STOP, input, 1 bit, one-cycle pulse that stops polling after the current transaction.
REQ-009 SHALL have port I_BUSY, input, 1 bit, MPU controller busy.
REQ-010 SHALL have port I_ERR, input, 1 bit, controller FSM error.
REQ-011 SHALL have port I_ACK_FL, input, 1 bit, I2C NACK flag.
REQ-012 SHALL have port I_RXD, input, 24 bits, controller receive buffer.
REQ-013 SHALL have port O_EN, output, 1 bit, controller enable pulse.
REQ-014 SHALL have port O_INSTR, output, 10 bits, instruction as {ROM addr A[4:0], ROM addr B[4:0]}.
REQ-015 SHALL have port O_SAMPLE, output, 16 bits, signed sensor word.
REQ-016 SHALL have port O_SAMPLE_ID, output, 3 bits, channel: 0..2 accel X/Y/Z, 3 temp, 4..6 gyro X/Y/Z.
REQ-017 SHALL have port O_SAMPLE_VLD, output, 1 bit, one-cycle strobe qualifying O_SAMPLE and O_SAMPLE_ID.
REQ-018 SHALL have port O_FRAME_CNT, output, 8 bits, number of completed frames.
REQ-019 SHALL have port O_OVERRUN, output, 1 bit, one-cycle strobe when a poll tick arrives during an active frame.
REQ-020 SHALL have port O_FAULT, output, 1 bit, retry budget exhausted.
REQ-021 SHALL have port O_ACTIVE, output, 1 bit, sequencer not in IDLE.

Function
REQ-022 SHALL use a 9-entry instruction table: index 0-1 init (wake, config), index 2-8 poll, with channel ID = index-2.
REQ-023 SHALL implement FSM states IDLE, ISSUE, WAIT_ACC, WAIT_DONE, CHECK, GAP, FAULT.
REQ-024 IDLE: on I_START SHALL set index to 0, clear the retry counter, and go to ISSUE.
REQ-025 ISSUE: SHALL assert O_EN high for exactly one cycle and go to WAIT_ACC.
REQ-026 O_INSTR SHALL hold table[index] stable from ISSUE until WAIT_DONE exits, and SHALL be 0 otherwise.
REQ-027 WAIT_ACC: when I_BUSY=1, SHALL go to WAIT_DONE; if ACC_TMO cycles elapse without I_BUSY=1, SHALL treat the transaction as failed and go to CHECK.
REQ-028 WAIT_DONE: on I_BUSY=0, SHALL sample I_ERR|I_ACK_FL as the fail condition and go to CHECK.
REQ-029 CHECK, fail path: SHALL increment the retry counter; if the counter < MAX_RETRY, SHALL go to ISSUE with the same index, else SHALL go to FAULT.
REQ-030 CHECK, success path: SHALL clear the retry counter; for index >= 2, SHALL drive O_SAMPLE=I_RXD[15:0], O_SAMPLE_ID=index-2, and O_SAMPLE_VLD=1 for one cycle.
REQ-031 CHECK, advance: for index < 8, SHALL increment index and go to ISSUE; at index 8, SHALL increment O_FRAME_CNT (wrapping 255->0), set index to 2, and go to GAP.
REQ-032 GAP: SHALL wait for the poll tick, then go to ISSUE.
REQ-033 The poll tick SHALL be a free-running pulse every FPGA_CLK/POLL_HZ cycles, independent of FSM state.
REQ-034 Overrun: a tick occurring while the FSM is not in GAP, after init has completed, SHALL pulse O_OVERRUN and SHALL be discarded, not queued.
REQ-035 I_STOP SHALL be latched; the latch SHALL be checked only in CHECK or GAP, so the in-flight transaction completes and its sample is still emitted; the FSM SHALL then go to IDLE and clear the latch.
REQ-036 FAULT: SHALL hold O_FAULT=1 with O_EN=0; I_START SHALL clear O_FAULT and restart from index 0; I_STOP SHALL be ignored in FAULT.
REQ-037 I_START SHALL be ignored outside IDLE and FAULT.
REQ-038 Simultaneous I_START and I_STOP in IDLE: I_START SHALL win and the stop latch SHALL be cleared.
REQ-039 O_ACTIVE SHALL be 0 in IDLE and 1 in all other states.

Reset
REQ-040 RST_n low SHALL force IDLE, index 0, retry counter 0, tick counter 0, and stop latch 0.
REQ-041 RST_n low SHALL drive all outputs to 0, including O_FRAME_CNT.
REQ-042 Reset mid-transaction SHALL abort immediately; recovery of the controller is its own responsibility.

Structure
REQ-043 Shared package mpu_pkg SHALL hold the FSM state enum, the 9-entry instruction table constants, and the channel ID constants.
REQ-044 The poll tick generator SHALL be a sub-module mpu_tick_gen (parameters FPGA_CLK, POLL_HZ; output tick pulse).

Verification
REQ-045 Scenario: I_START with a controller model (busy 20 cycles, no error) -> O_EN pulses with instructions for index 0..8, seven O_SAMPLE_VLD strobes with IDs 0..6 equal to model data, then O_FRAME_CNT=1.
REQ-046 Scenario: I_ACK_FL=1 on the first attempt of index 4 only -> index 4 is issued twice and ID 2 is emitted once.
REQ-047 Scenario: MAX_RETRY=3 with I_ERR always 1 on index 1 -> three issues, then O_FAULT=1 and O_EN silent; I_START -> O_FAULT=0 and index 0 is re-issued.
REQ-048 Scenario: I_BUSY never rises -> CHECK after 16 cycles and retry; O_FAULT=1 after 3 attempts.
REQ-049 Scenario: POLL_HZ set so the tick period < frame time -> O_OVERRUN pulses and the frame still completes.
REQ-050 Scenario: I_STOP during WAIT_DONE of index 5 -> ID 3 is emitted, then IDLE; RST_n low during WAIT_DONE -> all outputs 0 the same cycle.

Source files
------------

// File: rtl/mpu_pkg.sv
`default_nettype none
// ============================================================================
// mpu_pkg : shared FSM states, instruction table and channel IDs for MPU poll
// Revision 1.0
// ============================================================================
package mpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACC  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_CHECK     = 3'd4,
        ST_GAP       = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    localparam int         c_TBL_LEN   = 9;
    localparam logic [3:0] c_IDX_WAKE  = 4'd0;
    localparam logic [3:0] c_IDX_CFG   = 4'd1;
    localparam logic [3:0] c_IDX_POLL0 = 4'd2;
    localparam logic [3:0] c_IDX_LAST  = 4'd8;

    localparam logic [2:0] c_CH_ACC_X = 3'd0;
    localparam logic [2:0] c_CH_ACC_Y = 3'd1;
    localparam logic [2:0] c_CH_ACC_Z = 3'd2;
    localparam logic [2:0] c_CH_TEMP  = 3'd3;
    localparam logic [2:0] c_CH_GYR_X = 3'd4;
    localparam logic [2:0] c_CH_GYR_Y = 3'd5;
    localparam logic [2:0] c_CH_GYR_Z = 3'd6;

    // A selects the register-address ROM slot, B the payload/length ROM slot
    localparam logic [9:0] c_INSTR_WAKE  = {5'd0,  5'd1};
    localparam logic [9:0] c_INSTR_CFG   = {5'd2,  5'd3};
    localparam logic [9:0] c_INSTR_ACC_X = {5'd4,  5'd16};
    localparam logic [9:0] c_INSTR_ACC_Y = {5'd5,  5'd16};
    localparam logic [9:0] c_INSTR_ACC_Z = {5'd6,  5'd16};
    localparam logic [9:0] c_INSTR_TEMP  = {5'd7,  5'd16};
    localparam logic [9:0] c_INSTR_GYR_X = {5'd8,  5'd16};
    localparam logic [9:0] c_INSTR_GYR_Y = {5'd9,  5'd16};
    localparam logic [9:0] c_INSTR_GYR_Z = {5'd10, 5'd16};

    function automatic logic [9:0] instr_of(input logic [3:0] idx);
        case (idx)
            4'd0:    instr_of = c_INSTR_WAKE;
            4'd1:    instr_of = c_INSTR_CFG;
            4'd2:    instr_of = c_INSTR_ACC_X;
            4'd3:    instr_of = c_INSTR_ACC_Y;
            4'd4:    instr_of = c_INSTR_ACC_Z;
            4'd5:    instr_of = c_INSTR_TEMP;
            4'd6:    instr_of = c_INSTR_GYR_X;
            4'd7:    instr_of = c_INSTR_GYR_Y;
            4'd8:    instr_of = c_INSTR_GYR_Z;
            default: instr_of = '0;
        endcase
    endfunction

    function automatic logic [2:0] chan_of(input logic [3:0] idx);
        return 3'(idx - c_IDX_POLL0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mpu_tick_gen.sv
`default_nettype none
// ============================================================================
// mpu_tick_gen : free-running one-cycle pulse every FPGA_CLK/POLL_HZ clocks
// Revision 1.0
// ============================================================================
module mpu_tick_gen #(
    parameter int FPGA_CLK = 50_000_000,
    parameter int POLL_HZ  = 100
) (
    input  logic CLK,
    input  logic RST_n,
    output logic O_TICK
);

    localparam int c_PERIOD = ((FPGA_CLK / POLL_HZ) < 1) ? 1 : (FPGA_CLK / POLL_HZ);
    localparam int c_CW     = (c_PERIOD > 1) ? $clog2(c_PERIOD) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_PERIOD - 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign O_TICK = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mpu_poll_seq.sv
`default_nettype none
// ============================================================================
// mpu_poll_seq : wakes/configures the MPU, then polls 7 channels per frame tick
// Revision 1.0
// ============================================================================
module mpu_poll_seq
    import mpu_pkg::*;
#(
    parameter int FPGA_CLK  = 50_000_000,
    parameter int POLL_HZ   = 100,
    parameter int MAX_RETRY = 3,
    parameter int ACC_TMO   = 16
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        I_START,
    input  logic        I_STOP,
    input  logic        I_BUSY,
    input  logic        I_ERR,
    input  logic        I_ACK_FL,
    input  logic [23:0] I_RXD,
    output logic        O_EN,
    output logic [9:0]  O_INSTR,
    output logic [15:0] O_SAMPLE,
    output logic [2:0]  O_SAMPLE_ID,
    output logic        O_SAMPLE_VLD,
    output logic [7:0]  O_FRAME_CNT,
    output logic        O_OVERRUN,
    output logic        O_FAULT,
    output logic        O_ACTIVE
);

    localparam int c_RW = $clog2(MAX_RETRY + 1);
    localparam int c_AW = $clog2(ACC_TMO + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_idx;
    logic [c_RW-1:0] r_retry;
    logic [c_AW-1:0] r_acc_cnt;
    logic            r_fail;
    logic            r_stop_lat;
    logic [7:0]      r_frame_cnt;
    logic            w_tick;
    logic            w_acc_expired;
    logic            w_retry_ok;
    logic [7:0]      w_unused_rxd_hi;

    // Upper receive byte only matters for multi-byte reads this sequencer never issues
    assign w_unused_rxd_hi = I_RXD[23:16];

    mpu_tick_gen #(
        .FPGA_CLK (FPGA_CLK),
        .POLL_HZ  (POLL_HZ)
    ) u_tick_gen (
        .CLK    (CLK),
        .RST_n  (RST_n),
        .O_TICK (w_tick)
    );

    assign w_acc_expired = (r_acc_cnt == c_AW'(ACC_TMO - 1));
    assign w_retry_ok    = (int'(r_retry) + 1) < MAX_RETRY;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:      if (I_START) w_state_nxt = ST_ISSUE;
            ST_ISSUE:     w_state_nxt = ST_WAIT_ACC;
            ST_WAIT_ACC: begin
                if (I_BUSY)             w_state_nxt = ST_WAIT_DONE;
                else if (w_acc_expired) w_state_nxt = ST_CHECK;
            end
            ST_WAIT_DONE: if (!I_BUSY) w_state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (r_stop_lat)                w_state_nxt = ST_IDLE;
                else if (r_fail)               w_state_nxt = w_retry_ok ? ST_ISSUE : ST_FAULT;
                else if (r_idx == c_IDX_LAST)  w_state_nxt = ST_GAP;
                else                           w_state_nxt = ST_ISSUE;
            end
            ST_GAP: begin
                if (r_stop_lat)  w_state_nxt = ST_IDLE;
                else if (w_tick) w_state_nxt = ST_ISSUE;
            end
            ST_FAULT:     if (I_START) w_state_nxt = ST_ISSUE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_idx       <= c_IDX_WAKE;
            r_retry     <= '0;
            r_acc_cnt   <= '0;
            r_fail      <= 1'b0;
            r_stop_lat  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FAULT: begin
                    if (I_START) begin
                        r_idx   <= c_IDX_WAKE;
                        r_retry <= '0;
                    end
                end
                ST_ISSUE: begin
                    r_acc_cnt <= '0;
                    r_fail    <= 1'b0;
                end
                ST_WAIT_ACC: begin
                    if (!I_BUSY) begin
                        r_acc_cnt <= r_acc_cnt + 1'b1;
                        if (w_acc_expired) r_fail <= 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!I_BUSY) r_fail <= I_ERR | I_ACK_FL;
                end
                ST_CHECK: begin
                    if (r_fail) begin
                        r_retry <= r_retry + 1'b1;
                    end else begin
                        r_retry <= '0;
                        if (r_idx == c_IDX_LAST) begin
                            r_idx       <= c_IDX_POLL0;
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            // Stop is only honoured between transactions; IDLE/FAULT never hold it
            if (r_state == ST_IDLE || r_state == ST_FAULT || w_state_nxt == ST_IDLE) begin
                r_stop_lat <= 1'b0;
            end else if (I_STOP) begin
                r_stop_lat <= 1'b1;
            end
        end
    end

    assign O_FRAME_CNT = r_frame_cnt;

    always_comb begin
        O_EN         = 1'b0;
        O_INSTR      = '0;
        O_SAMPLE     = '0;
        O_SAMPLE_ID  = '0;
        O_SAMPLE_VLD = 1'b0;
        O_FAULT      = 1'b0;
        O_ACTIVE     = (r_state != ST_IDLE);
        O_OVERRUN    = w_tick && (r_idx >= c_IDX_POLL0) &&
                       (r_state inside {ST_ISSUE, ST_WAIT_ACC, ST_WAIT_DONE, ST_CHECK});
        case (r_state)
            ST_ISSUE: begin
                O_EN    = 1'b1;
                O_INSTR = instr_of(r_idx);
            end
            ST_WAIT_ACC, ST_WAIT_DONE: O_INSTR = instr_of(r_idx);
            ST_CHECK: begin
                if (!r_fail && r_idx >= c_IDX_POLL0) begin
                    O_SAMPLE_VLD = 1'b1;
                    O_SAMPLE     = I_RXD[15:0];
                    O_SAMPLE_ID  = chan_of(r_idx);
                end
            end
            ST_FAULT: O_FAULT = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mpu_poll_seq.sv
`default_nettype none
// ============================================================================
// tb_mpu_poll_seq : directed scenarios with a randomized controller model
// Revision 1.0
// ============================================================================
module tb_mpu_poll_seq;

    localparam int c_FPGA_CLK  = 100_000;
    localparam int c_POLL_HZ   = 100;
    localparam int c_MAX_RETRY = 3;
    localparam int c_ACC_TMO   = 16;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        I_START = 1'b0;
    logic        I_STOP = 1'b0;
    logic        I_BUSY = 1'b0;
    logic        I_ERR = 1'b0;
    logic        I_ACK_FL = 1'b0;
    logic [23:0] I_RXD = '0;
    logic        O_EN;
    logic [9:0]  O_INSTR;
    logic [15:0] O_SAMPLE;
    logic [2:0]  O_SAMPLE_ID;
    logic        O_SAMPLE_VLD;
    logic [7:0]  O_FRAME_CNT;
    logic        O_OVERRUN;
    logic        O_FAULT;
    logic        O_ACTIVE;

    always #5 CLK = ~CLK;

    mpu_poll_seq #(
        .FPGA_CLK  (c_FPGA_CLK),
        .POLL_HZ   (c_POLL_HZ),
        .MAX_RETRY (c_MAX_RETRY),
        .ACC_TMO   (c_ACC_TMO)
    ) dut (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .I_START      (I_START),
        .I_STOP       (I_STOP),
        .I_BUSY       (I_BUSY),
        .I_ERR        (I_ERR),
        .I_ACK_FL     (I_ACK_FL),
        .I_RXD        (I_RXD),
        .O_EN         (O_EN),
        .O_INSTR      (O_INSTR),
        .O_SAMPLE     (O_SAMPLE),
        .O_SAMPLE_ID  (O_SAMPLE_ID),
        .O_SAMPLE_VLD (O_SAMPLE_VLD),
        .O_FRAME_CNT  (O_FRAME_CNT),
        .O_OVERRUN    (O_OVERRUN),
        .O_FAULT      (O_FAULT),
        .O_ACTIVE     (O_ACTIVE)
    );

    int checks = 0;
    int failures = 0;

    // Controller model configuration
    int         busy_len   = 20;
    bit         no_busy    = 1'b0;
    logic [9:0] fail_instr = 10'h3FF;
    int         fail_times = 0;
    bit         fail_ack   = 1'b0;

    int         ctl_cnt   = 0;
    logic [9:0] cur_instr = '0;
    int         att       = 0;
    int         cyc       = 0;

    logic [9:0]  issue_q[$];
    int          issue_cyc_q[$];
    logic [18:0] got_q[$];
    logic [18:0] exp_q[$];
    int          ovr_cnt = 0;

    function automatic logic [9:0] tbl(input int i);
        case (i)
            0:       tbl = {5'd0, 5'd1};
            1:       tbl = {5'd2, 5'd3};
            default: tbl = {5'(i + 2), 5'd16};
        endcase
    endfunction

    function automatic int idx_of(input logic [9:0] ins);
        idx_of = -1;
        for (int i = 0; i < 9; i++) if (tbl(i) === ins) idx_of = i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_samples(input string tag, input int n);
        chk({tag, "_nsmp"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_smp"}, 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic clear_logs();
        issue_q.delete();
        issue_cyc_q.delete();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_start();
        I_START = 1'b1;
        @(negedge CLK);
        I_START = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int n, input int limit);
        for (int k = 0; k < limit && O_FRAME_CNT != 8'(n); k++) @(negedge CLK);
        chk(tag, 32'(O_FRAME_CNT), 32'(n));
    endtask

    // Monitor plus controller responder: busy for busy_len cycles, then result
    always @(negedge CLK) begin
        bit fail;
        int ix;
        cyc++;
        if (O_EN) begin
            issue_q.push_back(O_INSTR);
            issue_cyc_q.push_back(cyc);
        end
        if (O_SAMPLE_VLD) got_q.push_back({O_SAMPLE_ID, O_SAMPLE});
        if (O_OVERRUN) ovr_cnt++;
        if (!RST_n) begin
            ctl_cnt = 0;
            I_BUSY  = 1'b0;
        end else if (ctl_cnt > 0) begin
            ctl_cnt--;
            if (ctl_cnt == 0) begin
                fail     = (cur_instr == fail_instr) && (att <= fail_times);
                I_BUSY   = 1'b0;
                I_ERR    = fail && !fail_ack;
                I_ACK_FL = fail && fail_ack;
                I_RXD    = 24'($urandom);
                ix       = idx_of(cur_instr);
                if (!fail && ix >= 2) exp_q.push_back({3'(ix - 2), I_RXD[15:0]});
            end
        end else if (O_EN) begin
            att       = (O_INSTR == cur_instr) ? att + 1 : 1;
            cur_instr = O_INSTR;
            I_ERR     = 1'b0;
            I_ACK_FL  = 1'b0;
            if (!no_busy) begin
                I_BUSY  = 1'b1;
                ctl_cnt = busy_len;
            end
        end
    end

    initial begin
        int exp_iss[$];

        repeat (4) @(negedge CLK);
        chk("rst_en",     32'(O_EN), 0);
        chk("rst_instr",  32'(O_INSTR), 0);
        chk("rst_active", 32'(O_ACTIVE), 0);
        chk("rst_frame",  32'(O_FRAME_CNT), 0);
        chk("rst_fault",  32'(O_FAULT), 0);
        RST_n = 1'b1;
        repeat (3) @(negedge CLK);

        // Full init + first frame
        pulse_start();
        wait_frame("s1_frame", 1, 2000);
        chk("s1_nissue", 32'(issue_q.size()), 9);
        for (int i = 0; i < issue_q.size() && i < 9; i++) chk("s1_instr", 32'(issue_q[i]), 32'(tbl(i)));
        chk_samples("s1", 7);
        for (int i = 0; i < got_q.size(); i++) chk("s1_id", 32'(got_q[i][18:16]), 32'(i));
        chk("s1_gap_active", 32'(O_ACTIVE), 1);

        // NACK on first attempt of index 4
        clear_logs();
        ovr_cnt = 0; fail_instr = tbl(4); fail_times = 1; fail_ack = 1'b1;
        wait_frame("s2_frame", 2, 3000);
        exp_iss = '{2, 3, 4, 4, 5, 6, 7, 8};
        chk("s2_nissue", 32'(issue_q.size()), 8);
        for (int i = 0; i < issue_q.size() && i < 8; i++) chk("s2_instr", 32'(issue_q[i]), 32'(tbl(exp_iss[i])));
        chk_samples("s2", 7);
        for (int i = 0; i < got_q.size(); i++) chk("s2_id", 32'(got_q[i][18:16]), 32'(i));
        chk("s2_no_overrun", 32'(ovr_cnt), 0);
        fail_instr = 10'h3FF; fail_times = 0; fail_ack = 1'b0;

        // Stop during WAIT_DONE of index 5
        clear_logs();
        for (int k = 0; k < 3000 && !(O_INSTR == tbl(5) && I_BUSY); k++) @(negedge CLK);
        repeat (5) @(negedge CLK);
        chk("s3_in_wait", 32'(O_INSTR), 32'(tbl(5)));
        I_STOP = 1'b1;
        @(negedge CLK);
        I_STOP = 1'b0;
        for (int k = 0; k < 200 && O_ACTIVE; k++) @(negedge CLK);
        chk("s3_idle", 32'(O_ACTIVE), 0);
        repeat (30) @(negedge CLK);
        chk("s3_nissue", 32'(issue_q.size()), 4);
        chk_samples("s3", 4);
        if (got_q.size() > 0) chk("s3_last_id", 32'(got_q[got_q.size()-1][18:16]), 3);
        chk("s3_frame", 32'(O_FRAME_CNT), 2);

        // Persistent I_ERR on index 1 drives FAULT
        clear_logs();
        fail_instr = tbl(1); fail_times = 1000;
        pulse_start();
        for (int k = 0; k < 500 && !O_FAULT; k++) @(negedge CLK);
        chk("s4_fault", 32'(O_FAULT), 1);
        exp_iss = '{0, 1, 1, 1};
        chk("s4_nissue", 32'(issue_q.size()), 4);
        for (int i = 0; i < issue_q.size() && i < 4; i++) chk("s4_instr", 32'(issue_q[i]), 32'(tbl(exp_iss[i])));
        I_STOP = 1'b1;
        @(negedge CLK);
        I_STOP = 1'b0;
        repeat (40) @(negedge CLK);
        chk("s4_silent", 32'(issue_q.size()), 4);
        chk("s4_fault_held", 32'(O_FAULT), 1);
        chk("s4_active", 32'(O_ACTIVE), 1);

        // Restart from FAULT with a controller that never raises busy
        clear_logs();
        fail_instr = 10'h3FF; fail_times = 0; no_busy = 1'b1;
        pulse_start();
        chk("s5_fault_clr", 32'(O_FAULT), 0);
        chk("s5_restart_instr", 32'(O_INSTR), 32'(tbl(0)));
        for (int k = 0; k < 200 && !O_FAULT; k++) @(negedge CLK);
        chk("s5_fault", 32'(O_FAULT), 1);
        chk("s5_nissue", 32'(issue_q.size()), 3);
        for (int i = 0; i < issue_q.size(); i++) chk("s5_instr", 32'(issue_q[i]), 32'(tbl(0)));
        for (int i = 1; i < issue_cyc_q.size(); i++)
            chk("s5_spacing", 32'(issue_cyc_q[i] - issue_cyc_q[i-1]), 32'(c_ACC_TMO + 2));

        // Recover and finish a normal frame
        clear_logs();
        no_busy = 1'b0;
        pulse_start();
        wait_frame("s5b_frame", 3, 2000);
        chk_samples("s5b", 7);

        // Frame longer than the tick period: exactly one tick lands mid-frame
        clear_logs();
        ovr_cnt = 0; busy_len = 200;
        wait_frame("s6_frame", 4, 4000);
        chk("s6_overrun", 32'(ovr_cnt), 1);
        chk_samples("s6", 7);

        // Asynchronous reset while waiting on the controller
        for (int k = 0; k < 2000 && !(O_INSTR != 0 && I_BUSY); k++) @(negedge CLK);
        repeat (3) @(negedge CLK);
        chk("s7_pre_active", 32'(O_ACTIVE), 1);
        #2 RST_n = 1'b0;
        #1;
        chk("s7_active", 32'(O_ACTIVE), 0);
        chk("s7_instr",  32'(O_INSTR), 0);
        chk("s7_frame",  32'(O_FRAME_CNT), 0);
        chk("s7_en",     32'(O_EN), 0);
        chk("s7_vld",    32'(O_SAMPLE_VLD), 0);
        chk("s7_fault",  32'(O_FAULT), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
